// File: rtl/spike_router_rr.sv
// 3-port spike router (east, west, local) with input FIFOs and round-robin outputs.
// Define ROUTER_STATS_EN to add saturating per-output handshake counters.
module spike_router_rr #(
    parameter int PKT_W = 32,
    parameter int ID_W  = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ID_W-1:0]  core_id,
    input  logic             east_in_valid,
    output logic             east_in_ready,
    input  logic [PKT_W-1:0] east_in_pkt,
    input  logic             west_in_valid,
    output logic             west_in_ready,
    input  logic [PKT_W-1:0] west_in_pkt,
    input  logic             local_in_valid,
    output logic             local_in_ready,
    input  logic [PKT_W-1:0] local_in_pkt,
    output logic             east_out_valid,
    input  logic             east_out_ready,
    output logic [PKT_W-1:0] east_out_pkt,
    output logic             west_out_valid,
    input  logic             west_out_ready,
    output logic [PKT_W-1:0] west_out_pkt,
    output logic             sched_out_valid,
    input  logic             sched_out_ready,
    output logic [PKT_W-1:0] sched_out_pkt
`ifdef ROUTER_STATS_EN
    ,
    output logic [15:0]      stat_east,
    output logic [15:0]      stat_west,
    output logic [15:0]      stat_sched
`endif
);

    localparam int NP = 3;
    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    // Inputs: 0=east 1=west 2=local. Outputs: 0=east 1=west 2=sched.
    logic [NP-1:0]    in_valid;
    logic [NP-1:0]    in_ready;
    logic [NP-1:0]    push;
    logic [NP-1:0]    pop;
    logic [NP-1:0]    empty;
    logic [NP-1:0]    full;
    logic [PKT_W-1:0] in_pkt [NP];
    logic [PKT_W-1:0] head [NP];
    logic [ID_W-1:0]  dest [NP];
    logic [NP-1:0]    route [NP];
    logic [NP-1:0]    req [NP];
    logic [NP-1:0]    grant [NP];
    logic [PKT_W-1:0] sel_pkt [NP];
    logic [NP-1:0]    load;
    logic [NP-1:0]    fire;
    logic [NP-1:0]    out_ready;

    logic [PKT_W-1:0] mem_q [NP][DEPTH];
    logic [PKT_W-1:0] mem_d [NP][DEPTH];
    ptr_t             wr_ptr_q [NP];
    ptr_t             wr_ptr_d [NP];
    ptr_t             rd_ptr_q [NP];
    ptr_t             rd_ptr_d [NP];
    logic [NP-1:0]    out_valid_q;
    logic [NP-1:0]    out_valid_d;
    logic [PKT_W-1:0] out_pkt_q [NP];
    logic [PKT_W-1:0] out_pkt_d [NP];
    logic [1:0]       rr_ptr_q [NP];
    logic [1:0]       rr_ptr_d [NP];

    function automatic logic [NP-1:0] rr_pick(
        input logic [NP-1:0] r,
        input logic [1:0]    p
    );
        logic [NP-1:0] g;
        g = '0;
        case (p)
            2'd1: begin
                if (r[1])      g = 3'b010;
                else if (r[2]) g = 3'b100;
                else if (r[0]) g = 3'b001;
            end
            2'd2: begin
                if (r[2])      g = 3'b100;
                else if (r[0]) g = 3'b001;
                else if (r[1]) g = 3'b010;
            end
            default: begin
                if (r[0])      g = 3'b001;
                else if (r[1]) g = 3'b010;
                else if (r[2]) g = 3'b100;
            end
        endcase
        return g;
    endfunction

    function automatic logic [1:0] rr_next(input logic [NP-1:0] g);
        logic [1:0] n;
        n = 2'd0;
        if (g[0]) n = 2'd1;
        if (g[1]) n = 2'd2;
        return n;
    endfunction

    assign in_valid  = {local_in_valid, west_in_valid, east_in_valid};
    assign in_pkt[0] = east_in_pkt;
    assign in_pkt[1] = west_in_pkt;
    assign in_pkt[2] = local_in_pkt;
    assign out_ready = {sched_out_ready, west_out_ready, east_out_ready};

    assign east_in_ready  = in_ready[0];
    assign west_in_ready  = in_ready[1];
    assign local_in_ready = in_ready[2];

    assign east_out_valid  = out_valid_q[0];
    assign west_out_valid  = out_valid_q[1];
    assign sched_out_valid = out_valid_q[2];
    assign east_out_pkt    = out_pkt_q[0];
    assign west_out_pkt    = out_pkt_q[1];
    assign sched_out_pkt   = out_pkt_q[2];

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            empty[i]    = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]     = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                          (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
            in_ready[i] = !full[i];
            push[i]     = in_valid[i] && in_ready[i];
            head[i]     = mem_q[i][rd_ptr_q[i][AW-1:0]];
            dest[i]     = head[i][PKT_W-1 -: ID_W];
            if (dest[i] == core_id)     route[i] = 3'b100;
            else if (dest[i] > core_id) route[i] = 3'b001;
            else                        route[i] = 3'b010;
        end
    end

    always_comb begin
        for (int o = 0; o < NP; o++) begin
            for (int i = 0; i < NP; i++) begin
                req[o][i] = !empty[i] && route[i][o];
            end
        end
    end

    // An output loads when its register is empty or draining this cycle.
    always_comb begin
        for (int o = 0; o < NP; o++) begin
            grant[o]   = rr_pick(req[o], rr_ptr_q[o]);
            fire[o]    = out_valid_q[o] && out_ready[o];
            load[o]    = (|grant[o]) && (!out_valid_q[o] || out_ready[o]);
            sel_pkt[o] = '0;
            for (int i = 0; i < NP; i++) begin
                if (grant[o][i]) sel_pkt[o] = sel_pkt[o] | head[i];
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int o = 0; o < NP; o++) begin
            for (int i = 0; i < NP; i++) begin
                if (load[o] && grant[o][i]) pop[i] = 1'b1;
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NP; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + ptr_t'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + ptr_t'(pop[i]);
            if (push[i]) mem_d[i][wr_ptr_q[i][AW-1:0]] = in_pkt[i];
        end
    end

    always_comb begin
        for (int o = 0; o < NP; o++) begin
            out_valid_d[o] = out_valid_q[o];
            out_pkt_d[o]   = out_pkt_q[o];
            rr_ptr_d[o]    = rr_ptr_q[o];
            if (fire[o]) out_valid_d[o] = 1'b0;
            if (load[o]) begin
                out_valid_d[o] = 1'b1;
                out_pkt_d[o]   = sel_pkt[o];
                rr_ptr_d[o]    = rr_next(grant[o]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= '0;
            for (int i = 0; i < NP; i++) begin
                wr_ptr_q[i]  <= '0;
                rd_ptr_q[i]  <= '0;
                out_pkt_q[i] <= '0;
                rr_ptr_q[i]  <= 2'd0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            for (int i = 0; i < NP; i++) begin
                wr_ptr_q[i]  <= wr_ptr_d[i];
                rd_ptr_q[i]  <= rd_ptr_d[i];
                out_pkt_q[i] <= out_pkt_d[i];
                rr_ptr_q[i]  <= rr_ptr_d[i];
            end
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef ROUTER_STATS_EN
    logic [15:0] stat_q [NP];
    logic [15:0] stat_d [NP];

    always_comb begin
        for (int o = 0; o < NP; o++) begin
            stat_d[o] = stat_q[o];
            if (fire[o] && stat_q[o] != 16'hFFFF) stat_d[o] = stat_q[o] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NP; o++) stat_q[o] <= '0;
        end else begin
            for (int o = 0; o < NP; o++) stat_q[o] <= stat_d[o];
        end
    end

    assign stat_east  = stat_q[0];
    assign stat_west  = stat_q[1];
    assign stat_sched = stat_q[2];
`endif

endmodule

// File: tb/tb_spike_router_rr.sv
// Directed bench for spike_router_rr: routing, fairness, backpressure,
// head-of-line blocking, mid-flow reset and (optionally) the stats counters.
module tb_spike_router_rr;

    localparam int PKT_W = 32;
    localparam int ID_W  = 2;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [ID_W-1:0]  core_id;
    logic             east_in_valid, east_in_ready;
    logic [PKT_W-1:0] east_in_pkt;
    logic             west_in_valid, west_in_ready;
    logic [PKT_W-1:0] west_in_pkt;
    logic             local_in_valid, local_in_ready;
    logic [PKT_W-1:0] local_in_pkt;
    logic             east_out_valid, east_out_ready;
    logic [PKT_W-1:0] east_out_pkt;
    logic             west_out_valid, west_out_ready;
    logic [PKT_W-1:0] west_out_pkt;
    logic             sched_out_valid, sched_out_ready;
    logic [PKT_W-1:0] sched_out_pkt;
`ifdef ROUTER_STATS_EN
    logic [15:0]      stat_east, stat_west, stat_sched;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spike_router_rr #(.PKT_W(PKT_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .core_id         (core_id),
        .east_in_valid   (east_in_valid),
        .east_in_ready   (east_in_ready),
        .east_in_pkt     (east_in_pkt),
        .west_in_valid   (west_in_valid),
        .west_in_ready   (west_in_ready),
        .west_in_pkt     (west_in_pkt),
        .local_in_valid  (local_in_valid),
        .local_in_ready  (local_in_ready),
        .local_in_pkt    (local_in_pkt),
        .east_out_valid  (east_out_valid),
        .east_out_ready  (east_out_ready),
        .east_out_pkt    (east_out_pkt),
        .west_out_valid  (west_out_valid),
        .west_out_ready  (west_out_ready),
        .west_out_pkt    (west_out_pkt),
        .sched_out_valid (sched_out_valid),
        .sched_out_ready (sched_out_ready),
        .sched_out_pkt   (sched_out_pkt)
`ifdef ROUTER_STATS_EN
        ,
        .stat_east       (stat_east),
        .stat_west       (stat_west),
        .stat_sched      (stat_sched)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] valids();
        return {sched_out_valid, west_out_valid, east_out_valid};
    endfunction

    function automatic logic [2:0] readies();
        return {local_in_ready, west_in_ready, east_in_ready};
    endfunction

    function automatic logic [31:0] out_pkt(input int p);
        if (p == 0) return east_out_pkt;
        if (p == 1) return west_out_pkt;
        return sched_out_pkt;
    endfunction

    // Port p: 0=east 1=west 2=sched. Called on a falling edge.
    task automatic route_one(input string tag, input logic [31:0] pkt,
                             input int p);
        local_in_valid = 1'b1;
        local_in_pkt   = pkt;
        @(negedge clk);
        local_in_valid = 1'b0;
        check({tag, "_early"}, 32'(valids()), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(valids()), 32'(3'b001 << p));
        check({tag, "_pkt"}, out_pkt(p), pkt);
        @(negedge clk);
        check({tag, "_drain"}, 32'(valids()), 32'd0);
    endtask

    logic [31:0] e_pk [4];
    logic [31:0] w_pk [4];
    logic [31:0] exp_pk;

    initial begin
        rst             = 1'b1;
        core_id         = 2'd1;
        east_in_valid   = 1'b0;
        west_in_valid   = 1'b0;
        local_in_valid  = 1'b0;
        east_in_pkt     = '0;
        west_in_pkt     = '0;
        local_in_pkt    = '0;
        east_out_ready  = 1'b1;
        west_out_ready  = 1'b1;
        sched_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_valid", 32'(valids()), 32'd0);
        check("rst_ready", 32'(readies()), 32'h7);
        check("rst_epkt", east_out_pkt, 32'd0);
        check("rst_wpkt", west_out_pkt, 32'd0);
        check("rst_spkt", sched_out_pkt, 32'd0);

        route_one("r_sched", 32'h4000_00AA, 2);
        route_one("r_east", 32'h8000_0055, 0);
        route_one("r_west", 32'h0000_0011, 1);
        route_one("r_end", 32'hC000_0077, 0);

        for (int k = 0; k < 4; k++) begin
            e_pk[k] = 32'h4000_0E00 + 32'(k);
            w_pk[k] = 32'h4000_0B00 + 32'(k);
        end
        for (int n = 0; n < 10; n++) begin
            if (n >= 2) begin
                exp_pk = ((n - 2) % 2 == 0) ? e_pk[(n - 2) / 2] : w_pk[(n - 2) / 2];
                check("rr_valid", 32'(sched_out_valid), 32'd1);
                check("rr_pkt", sched_out_pkt, exp_pk);
            end
            if (n < 4) begin
                east_in_valid = 1'b1;
                east_in_pkt   = e_pk[n];
                west_in_valid = 1'b1;
                west_in_pkt   = w_pk[n];
            end else begin
                east_in_valid = 1'b0;
                west_in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("rr_idle", 32'(valids()), 32'd0);

        east_out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            check("bp_ready_pre", 32'(local_in_ready), 32'd1);
            local_in_valid = 1'b1;
            local_in_pkt   = 32'hC000_0000 + 32'(n);
            @(negedge clk);
        end
        local_in_valid = 1'b0;
        check("bp_full", 32'(local_in_ready), 32'd0);
        for (int n = 0; n < 3; n++) begin
            check("bp_hold_v", 32'(east_out_valid), 32'd1);
            check("bp_hold_pkt", east_out_pkt, 32'hC000_0000);
            @(negedge clk);
        end
        east_out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check("bp_rel_v", 32'(east_out_valid), 32'd1);
            check("bp_rel_pkt", east_out_pkt, 32'hC000_0000 + 32'(k));
        end
        @(negedge clk);
        check("bp_done_v", 32'(east_out_valid), 32'd0);
        check("bp_done_rdy", 32'(local_in_ready), 32'd1);

        east_out_ready = 1'b0;
        local_in_valid = 1'b1;
        local_in_pkt   = 32'hC000_00A1;
        @(negedge clk);
        local_in_pkt   = 32'hC000_00A2;
        @(negedge clk);
        local_in_pkt   = 32'h4000_00B1;
        @(negedge clk);
        local_in_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("hol_sched_v", 32'(sched_out_valid), 32'd0);
            check("hol_east_pkt", east_out_pkt, 32'hC000_00A1);
        end
        east_out_ready = 1'b1;
        @(negedge clk);
        check("hol_e2_v", 32'(east_out_valid), 32'd1);
        check("hol_e2_pkt", east_out_pkt, 32'hC000_00A2);
        check("hol_s_wait", 32'(sched_out_valid), 32'd0);
        @(negedge clk);
        check("hol_s_v", 32'(sched_out_valid), 32'd1);
        check("hol_s_pkt", sched_out_pkt, 32'h4000_00B1);
        check("hol_e_idle", 32'(east_out_valid), 32'd0);
        @(negedge clk);

        east_out_ready = 1'b0;
        local_in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            local_in_pkt = 32'hC000_0010 + 32'(n);
            @(negedge clk);
        end
        local_in_valid = 1'b0;
        check("mr_pre_v", 32'(east_out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_valid", 32'(valids()), 32'd0);
        check("mr_ready", 32'(readies()), 32'h7);
        check("mr_epkt", east_out_pkt, 32'd0);
        east_out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("mr_stale", 32'(valids()), 32'd0);
        end

`ifdef ROUTER_STATS_EN
        check("st_start", 32'(stat_sched), 32'd0);
        local_in_valid = 1'b1;
        local_in_pkt   = 32'h4000_0001;
        repeat (70000) @(negedge clk);
        local_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("st_sat", 32'(stat_sched), 32'hFFFF);
        check("st_east", 32'(stat_east), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("st_clr", 32'(stat_sched), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
